// File: rtl/id_ex_stage_reg_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_reg_if
//  Description : ID->EX bundle: decoded control, operands, flush/stall and
//                the bubble counter.
//  Revision    : 1.0
// ============================================================================
interface id_ex_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    logic              id_reg_dest, id_branch, id_mem_read, id_mem_to_reg;
    logic              id_mem_write, id_alu_src, id_reg_write;
    logic [1:0]        id_alu_op;
    logic [DATA_W-1:0] id_pc_plus4, id_read_data1, id_read_data2, id_imm;
    logic [4:0]        id_rs, id_rt, id_rd;
    logic              flush;

    logic              ex_reg_dest, ex_branch, ex_mem_read, ex_mem_to_reg;
    logic              ex_mem_write, ex_alu_src, ex_reg_write;
    logic [1:0]        ex_alu_op;
    logic [DATA_W-1:0] ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm;
    logic [4:0]        ex_rs, ex_rt, ex_rd;
    logic              ex_valid;
    logic              stall_out;
    logic [CNT_W-1:0]  bubble_count;

    modport master (
        output id_reg_dest, id_branch, id_mem_read, id_mem_to_reg,
               id_mem_write, id_alu_src, id_reg_write, id_alu_op,
               id_pc_plus4, id_read_data1, id_read_data2, id_imm,
               id_rs, id_rt, id_rd, flush,
        input  ex_reg_dest, ex_branch, ex_mem_read, ex_mem_to_reg,
               ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op,
               ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_valid, stall_out, bubble_count
    );

    modport slave (
        input  id_reg_dest, id_branch, id_mem_read, id_mem_to_reg,
               id_mem_write, id_alu_src, id_reg_write, id_alu_op,
               id_pc_plus4, id_read_data1, id_read_data2, id_imm,
               id_rs, id_rt, id_rd, flush,
        output ex_reg_dest, ex_branch, ex_mem_read, ex_mem_to_reg,
               ex_mem_write, ex_alu_src, ex_reg_write, ex_alu_op,
               ex_pc_plus4, ex_read_data1, ex_read_data2, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_valid, stall_out, bubble_count
    );
endinterface
`default_nettype wire

// File: rtl/id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_stage_reg
//  Description : ID/EX pipeline register with load-use bubble insertion.
//                Hazard detector built only when ID_EX_LOAD_USE_EN is defined.
//  Revision    : 1.0
// ============================================================================
module id_ex_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    id_ex_stage_reg_if.slave bus
);
    localparam int c_CTRL_W   = 9;
    localparam int c_MEM_READ = 6;

    // {reg_dest, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
    logic [c_CTRL_W-1:0] w_id_ctrl;
    logic [c_CTRL_W-1:0] ctrl_d, ctrl_q;
    logic                valid_d, valid_q;
    logic [DATA_W-1:0]   pc_q, rd1_q, rd2_q, imm_q;
    logic [4:0]          rs_q, rt_q, rd_q;
    logic                w_stall;

    assign w_id_ctrl = {bus.id_reg_dest, bus.id_branch, bus.id_mem_read,
                        bus.id_mem_to_reg, bus.id_mem_write, bus.id_alu_src,
                        bus.id_reg_write, bus.id_alu_op};

    always_comb begin
        ctrl_d  = w_id_ctrl;
        valid_d = 1'b1;
        if (bus.flush || w_stall) begin
            ctrl_d  = '0;
            valid_d = 1'b0;
        end
    end

    // Operand/field registers load unconditionally; they are don't-care under a bubble.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ctrl_q  <= '0;
            valid_q <= 1'b0;
            pc_q    <= '0;
            rd1_q   <= '0;
            rd2_q   <= '0;
            imm_q   <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
        end else begin
            ctrl_q  <= ctrl_d;
            valid_q <= valid_d;
            pc_q    <= bus.id_pc_plus4;
            rd1_q   <= bus.id_read_data1;
            rd2_q   <= bus.id_read_data2;
            imm_q   <= bus.id_imm;
            rs_q    <= bus.id_rs;
            rt_q    <= bus.id_rt;
            rd_q    <= bus.id_rd;
        end
    end

`ifdef ID_EX_LOAD_USE_EN
    logic             w_uses_rt;
    logic             w_hazard;
    logic [CNT_W-1:0] bubble_d, bubble_q;

    assign w_uses_rt = !bus.id_alu_src || bus.id_mem_write;
    assign w_hazard  = ctrl_q[c_MEM_READ] && (rt_q != 5'd0) &&
                       ((rt_q == bus.id_rs) || (w_uses_rt && (rt_q == bus.id_rt)));
    // Flush wins: the redirected front end must not be held.
    assign w_stall   = w_hazard && !bus.flush;

    always_comb begin
        bubble_d = bubble_q;
        if (w_stall && (bubble_q != {CNT_W{1'b1}}))
            bubble_d = bubble_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            bubble_q <= '0;
        else
            bubble_q <= bubble_d;
    end

    assign bus.bubble_count = bubble_q;
`else
    assign w_stall          = 1'b0;
    assign bus.bubble_count = {CNT_W{1'b0}};
`endif

    assign bus.stall_out     = w_stall;
    assign bus.ex_reg_dest   = ctrl_q[8];
    assign bus.ex_branch     = ctrl_q[7];
    assign bus.ex_mem_read   = ctrl_q[6];
    assign bus.ex_mem_to_reg = ctrl_q[5];
    assign bus.ex_mem_write  = ctrl_q[4];
    assign bus.ex_alu_src    = ctrl_q[3];
    assign bus.ex_reg_write  = ctrl_q[2];
    assign bus.ex_alu_op     = ctrl_q[1:0];
    assign bus.ex_valid      = valid_q;
    assign bus.ex_pc_plus4   = pc_q;
    assign bus.ex_read_data1 = rd1_q;
    assign bus.ex_read_data2 = rd2_q;
    assign bus.ex_imm        = imm_q;
    assign bus.ex_rs         = rs_q;
    assign bus.ex_rt         = rt_q;
    assign bus.ex_rd         = rd_q;
endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_ex_stage_reg
//  Description : Directed vector bench for id_ex_stage_reg (CNT_W=4).
//  Revision    : 1.0
// ============================================================================
module tb_id_ex_stage_reg;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
`ifdef ID_EX_LOAD_USE_EN
    localparam bit LUE = 1'b1;
`else
    localparam bit LUE = 1'b0;
`endif

    // {reg_dest, branch, mem_read, mem_to_reg, mem_write, alu_src, reg_write, alu_op}
    localparam logic [8:0] c_LW   = 9'b001101100;
    localparam logic [8:0] c_ADD  = 9'b100000110;
    localparam logic [8:0] c_ADDI = 9'b000001110;
    localparam logic [8:0] c_SW   = 9'b000011000;
    localparam logic [8:0] c_BEQ  = 9'b010000001;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    id_ex_stage_reg_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();
    id_ex_stage_reg #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [8:0]  ctrl;
        logic [4:0]  rs, rt, rd;
        logic [31:0] imm;
        logic        flush;
        logic        exp_haz;   // stall expected when detector is built
        int          exp_bub;   // bubble_count after the edge when detector is built
    } vec_t;

    vec_t vecs[17];

    function automatic vec_t mk(logic [8:0] c, logic [4:0] rs, logic [4:0] rt,
                                logic [4:0] rd, logic [31:0] imm, logic fl,
                                logic haz, int bub);
        vec_t v;
        v.ctrl = c; v.rs = rs; v.rt = rt; v.rd = rd; v.imm = imm;
        v.flush = fl; v.exp_haz = haz; v.exp_bub = bub;
        return v;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(logic [8:0] c, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
                         logic [31:0] imm, logic fl, int tag);
        {bus.id_reg_dest, bus.id_branch, bus.id_mem_read, bus.id_mem_to_reg,
         bus.id_mem_write, bus.id_alu_src, bus.id_reg_write, bus.id_alu_op} = c;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd; bus.id_imm = imm;
        bus.flush = fl;
        bus.id_pc_plus4   = 32'h0000_0400 + 32'(tag) * 4;
        bus.id_read_data1 = 32'hA000_0000 | 32'(tag);
        bus.id_read_data2 = 32'hB000_0000 | 32'(tag);
    endtask

    function automatic logic [8:0] ex_ctrl();
        return {bus.ex_reg_dest, bus.ex_branch, bus.ex_mem_read, bus.ex_mem_to_reg,
                bus.ex_mem_write, bus.ex_alu_src, bus.ex_reg_write, bus.ex_alu_op};
    endfunction

    initial begin
        logic exp_stall, exp_valid;
        int   exp_bub;

        vecs[0]  = mk(c_ADDI, 5'd2, 5'd3, 5'd0,  32'h5, 1'b0, 1'b0, 0);
        vecs[1]  = mk(c_LW,   5'd1, 5'd8, 5'd0,  32'h4, 1'b0, 1'b0, 0);
        vecs[2]  = mk(c_ADD,  5'd8, 5'd9, 5'd10, 32'h0, 1'b0, 1'b1, 1);
        vecs[3]  = mk(c_ADD,  5'd8, 5'd9, 5'd10, 32'h0, 1'b0, 1'b0, 1);
        vecs[4]  = mk(c_LW,   5'd1, 5'd8, 5'd0,  32'h8, 1'b0, 1'b0, 1);
        vecs[5]  = mk(c_ADDI, 5'd4, 5'd8, 5'd0,  32'h7, 1'b0, 1'b0, 1);
        vecs[6]  = mk(c_LW,   5'd1, 5'd0, 5'd0,  32'hC, 1'b0, 1'b0, 1);
        vecs[7]  = mk(c_ADD,  5'd0, 5'd0, 5'd5,  32'h0, 1'b0, 1'b0, 1);
        vecs[8]  = mk(c_LW,   5'd1, 5'd7, 5'd0,  32'h10, 1'b0, 1'b0, 1);
        vecs[9]  = mk(c_SW,   5'd1, 5'd7, 5'd0,  32'h14, 1'b0, 1'b1, 2);
        vecs[10] = mk(c_SW,   5'd1, 5'd7, 5'd0,  32'h14, 1'b0, 1'b0, 2);
        vecs[11] = mk(c_LW,   5'd1, 5'd6, 5'd0,  32'h18, 1'b0, 1'b0, 2);
        vecs[12] = mk(c_ADD,  5'd6, 5'd9, 5'd11, 32'h0, 1'b1, 1'b0, 2);
        vecs[13] = mk(c_BEQ,  5'd6, 5'd6, 5'd0,  32'hFFFF_FFFC, 1'b0, 1'b0, 2);
        vecs[14] = mk(c_LW,   5'd1, 5'd6, 5'd0,  32'h1C, 1'b0, 1'b0, 2);
        vecs[15] = mk(c_ADD,  5'd1, 5'd6, 5'd2,  32'h0, 1'b0, 1'b1, 3);
        vecs[16] = mk(c_ADD,  5'd1, 5'd6, 5'd2,  32'h0, 1'b0, 1'b0, 3);

        // Reset with busy inputs
        drive(9'h1FF, 5'd31, 5'd31, 5'd31, 32'hDEAD_BEEF, 1'b0, 99);
        @(posedge clk); #1;
        chk("rst ctrl",   64'(ex_ctrl()), 64'h0);
        chk("rst valid",  64'(bus.ex_valid), 64'h0);
        chk("rst pc",     64'(bus.ex_pc_plus4), 64'h0);
        chk("rst imm",    64'(bus.ex_imm), 64'h0);
        chk("rst rt",     64'(bus.ex_rt), 64'h0);
        chk("rst bubble", 64'(bus.bubble_count), 64'h0);
        chk("rst stall",  64'(bus.stall_out), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            drive(vecs[i].ctrl, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].imm,
                  vecs[i].flush, i);
            exp_stall = vecs[i].exp_haz && LUE;
            #1;
            chk($sformatf("v%0d stall", i), 64'(bus.stall_out), 64'(exp_stall));
            @(posedge clk); #1;
            exp_valid = !(vecs[i].flush || exp_stall);
            exp_bub   = LUE ? vecs[i].exp_bub : 0;
            chk($sformatf("v%0d valid", i), 64'(bus.ex_valid), 64'(exp_valid));
            chk($sformatf("v%0d ctrl", i), 64'(ex_ctrl()),
                exp_valid ? 64'(vecs[i].ctrl) : 64'h0);
            chk($sformatf("v%0d bubble", i), 64'(bus.bubble_count), 64'(exp_bub));
            if (exp_valid) begin
                chk($sformatf("v%0d pc", i),  64'(bus.ex_pc_plus4), 64'(32'h400 + 32'(i) * 4));
                chk($sformatf("v%0d rd1", i), 64'(bus.ex_read_data1), 64'(32'hA000_0000 | 32'(i)));
                chk($sformatf("v%0d rd2", i), 64'(bus.ex_read_data2), 64'(32'hB000_0000 | 32'(i)));
                chk($sformatf("v%0d imm", i), 64'(bus.ex_imm), 64'(vecs[i].imm));
                chk($sformatf("v%0d rs", i),  64'(bus.ex_rs), 64'(vecs[i].rs));
                chk($sformatf("v%0d rt", i),  64'(bus.ex_rt), 64'(vecs[i].rt));
                chk($sformatf("v%0d rd", i),  64'(bus.ex_rd), 64'(vecs[i].rd));
            end
        end

        // Saturation: 17 further load-use pairs on top of the 3 bubbles already counted
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk);
            drive(c_LW, 5'd1, 5'd8, 5'd0, 32'h20, 1'b0, 200 + k);
            @(negedge clk);
            drive(c_ADD, 5'd8, 5'd9, 5'd3, 32'h0, 1'b0, 300 + k);
            #1;
            chk($sformatf("sat%0d stall", k), 64'(bus.stall_out), 64'(LUE));
            @(posedge clk); #1;
            exp_bub = LUE ? ((3 + k > 15) ? 15 : 3 + k) : 0;
            chk($sformatf("sat%0d bubble", k), 64'(bus.bubble_count), 64'(exp_bub));
        end
        chk("sat final", 64'(bus.bubble_count), LUE ? 64'hF : 64'h0);

        // Reset asserted in the middle of a stall cycle
        @(negedge clk);
        drive(c_LW, 5'd1, 5'd8, 5'd0, 32'h24, 1'b0, 400);
        @(negedge clk);
        drive(c_ADD, 5'd8, 5'd9, 5'd3, 32'h0, 1'b0, 401);
        #1;
        chk("midrst pre stall", 64'(bus.stall_out), 64'(LUE));
        #1;
        reset_n = 1'b0;
        #1;
        chk("midrst stall",  64'(bus.stall_out), 64'h0);
        chk("midrst ctrl",   64'(ex_ctrl()), 64'h0);
        chk("midrst valid",  64'(bus.ex_valid), 64'h0);
        chk("midrst pc",     64'(bus.ex_pc_plus4), 64'h0);
        chk("midrst bubble", 64'(bus.bubble_count), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        drive(c_ADDI, 5'd2, 5'd3, 5'd0, 32'h5, 1'b0, 500);
        @(posedge clk); #1;
        chk("post rst valid", 64'(bus.ex_valid), 64'h1);
        chk("post rst ctrl",  64'(ex_ctrl()), 64'(c_ADDI));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
